serial_frame_loader: RTL and testbench

- Upstream feeder for the team's WIDTH-bit load-enable `register`.
- Collects a serial bit stream framed by a start pulse and assembles it into a WIDTH-bit word.
- Presents the word on `par_out` with a one-cycle `load` strobe. Both connect directly to the register's `data_in` and `load`.
- Reports aborted frames on `frame_err`.

---
 rtl/serial_frame_loader_pkg.sv | 7 +
 rtl/serial_frame_loader_shift_collector.sv | 34 +++
 rtl/serial_frame_loader.sv | 51 +++++
 tb/tb_serial_frame_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_frame_loader_pkg.sv
// frame_pkg: shared state encoding and counter sizing for serial_frame_loader.
package frame_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/serial_frame_loader_shift_collector.sv
// shift_collector: serial-to-parallel shift register with a bit counter.
module shift_collector
    import frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             last_bit
);
    localparam int CNT_W = cnt_w(WIDTH);
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    // word is the value the register takes if bit_in is shifted in this cycle
    assign word     = MSB_FIRST ? {sreg[WIDTH-2:0], bit_in} : {bit_in, sreg[WIDTH-1:1]};
    assign last_bit = cnt == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= word;
            cnt  <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/serial_frame_loader.sv
// serial_frame_loader: assembles start-framed serial bits into a word with a load strobe.
module serial_frame_loader
    import frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             load,
    output logic             busy,
    output logic             frame_err
);
    state_t           state, next;
    logic             shift_en, done_bit, last_bit;
    logic [WIDTH-1:0] word;
    shift_collector #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_col (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .shift_en (shift_en),
        .bit_in   (ser_in),
        .word     (word),
        .last_bit (last_bit)
    );
    // start always wins: it opens a frame from any state and the bit beside it is dropped
    always_comb begin
        shift_en = state == SHIFT && ser_valid && !start;
        done_bit = shift_en && last_bit;
        next     = start ? SHIFT : done_bit ? DONE : state == SHIFT ? SHIFT : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            par_out   <= '0;
            load      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= next;
            load      <= done_bit;
            busy      <= next == SHIFT;
            frame_err <= state == SHIFT && start;
            if (done_bit) par_out <= word;
        end
    end
endmodule

// File: tb/tb_serial_frame_loader.sv
// tb_serial_frame_loader: directed and random frames checked against a queue-based model.
module tb_serial_frame_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, ser_valid = 1'b0, ser_in = 1'b0;
    logic [7:0] par_m, par_l, reg_q;
    logic       load_m, busy_m, err_m, load_l, busy_l, err_l;
    int         total = 0, passed = 0;
    logic       bits[$];
    logic       m_in = 1'b0, m_done = 1'b0;
    logic [7:0] e_par_m = '0, e_par_l = '0, e_reg = '0;
    logic       e_load = 1'b0, e_busy = 1'b0, e_err = 1'b0;

    always #5 clk = ~clk;

    serial_frame_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_in(ser_in),
        .par_out(par_m), .load(load_m), .busy(busy_m), .frame_err(err_m)
    );
    serial_frame_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_in(ser_in),
        .par_out(par_l), .load(load_l), .busy(busy_l), .frame_err(err_l)
    );

    // downstream load-enable register fed by the MSB-first loader
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) reg_q <= '0;
        else if (load_m) reg_q <= par_m;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        check("par_msb", 32'(par_m), 32'(e_par_m));
        check("par_lsb", 32'(par_l), 32'(e_par_l));
        check("load_msb", 32'(load_m), 32'(e_load));
        check("load_lsb", 32'(load_l), 32'(e_load));
        check("busy_msb", 32'(busy_m), 32'(e_busy));
        check("busy_lsb", 32'(busy_l), 32'(e_busy));
        check("err_msb", 32'(err_m), 32'(e_err));
        check("err_lsb", 32'(err_l), 32'(e_err));
        check("down_reg", 32'(reg_q), 32'(e_reg));
    endtask

    task automatic model_reset();
        bits.delete();
        m_in = 0; m_done = 0;
        e_par_m = '0; e_par_l = '0; e_reg = '0;
        e_load = 0; e_busy = 0; e_err = 0;
    endtask

    task automatic model_edge(input logic s, input logic v, input logic b);
        if (e_load) e_reg = e_par_m;
        e_load = 0;
        e_err  = 0;
        if (m_done) begin
            m_done = 0;
            m_in   = s;
            bits.delete();
        end else if (!m_in) begin
            if (s) begin m_in = 1; bits.delete(); end
        end else if (s) begin
            e_err = 1;
            bits.delete();
        end else if (v) begin
            bits.push_back(b);
            if (bits.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    e_par_m[7-i] = bits[i];
                    e_par_l[i]   = bits[i];
                end
                e_load = 1;
                m_in   = 0;
                m_done = 1;
            end
        end
        e_busy = m_in;
    endtask

    task automatic step(input logic s, input logic v, input logic b);
        start = s; ser_valid = v; ser_in = b;
        @(posedge clk);
        model_edge(s, v, b);
        @(negedge clk);
        check_all();
    endtask

    task automatic frame(input logic [7:0] w, input int gap);
        step(1, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, w[i]);
            if (gap > 0 && (i == 6 || i == 2))
                for (int g = 0; g < gap; g++) step(0, 0, 1);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        #1 rst = 1'b1;
    endtask

    initial begin
        #3 check_all();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 1);
        frame(8'hA5, 0);
        step(0, 0, 0);
        frame(8'hA5, 3);
        step(0, 1, 0);
        step(1, 1, 1);
        step(0, 1, 1); step(0, 1, 1); step(0, 0, 0); step(0, 1, 1);
        frame(8'h3C, 0);
        step(0, 0, 0);
        frame(8'hA5, 0);
        frame(8'h0F, 0);
        step(0, 0, 0);
        frame(8'hC0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1);
        async_reset();
        frame(8'hC3, 0);
        step(0, 0, 0);
        check("reg_c3", 32'(reg_q), 32'h0000_00C3);
        for (int n = 0; n < 1500; n++) begin
            if (n == 700 || n == 1200) async_reset();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
